ecg_play_ctrl: RTL and testbench

- Playback sequencer for the ECG waveform LUT in the signal-generator test path.
- Runs a phase accumulator that drives the LUT's 10-bit address and captures the combinational LUT output on each sample tick.
- Applies gain with saturation and presents samples on a valid/ready stream toward the audio/DAC datapath.
- Handles start/stop (stop finishes the current beat), beat pacing and beat counting.

---
 rtl/ecg_play_ctrl.sv | 140 ++++++++++++++
 tb/tb_ecg_play_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_play_ctrl.sv
// ECG waveform playback sequencer.
// A phase accumulator walks the ECG LUT. Each sample tick captures the LUT
// word, scales it by a Q1.7 gain with saturation, and presents it on an
// output stream.
// Output stream handshake: out_data is held stable while out_valid is high.
// A sample is transferred on any clock edge where out_valid and out_ready
// are both high. out_valid never drops until that transfer happens.
module ecg_play_ctrl #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int GAIN_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [GAIN_W-1:0]  gain,
  output logic [ADDR_W-1:0]  lut_addr,
  input  logic [DATA_W-1:0]  lut_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               beat_pulse,
  output logic [15:0]        beat_count,
  output logic               overrun
);

  localparam int P_W = DATA_W + GAIN_W + 1;
  localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [P_W-1:0] SAT_MIN = {{(P_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PHASE_W-1:0]   phase_acc;
  logic [PHASE_W-1:0]   inc_reg;
  logic [PHASE_W:0]     sum;
  logic                 tick_act;
  logic                 wrap;
  logic signed [P_W-1:0] prod;
  logic signed [P_W-1:0] shifted;
  logic [DATA_W-1:0]    sat_val;

  // A tick only counts while playing. A carry out of the accumulator marks a beat boundary.
  assign tick_act = sample_tick && (state != S_IDLE);
  assign sum      = {1'b0, phase_acc} + {1'b0, inc_reg};
  assign wrap     = tick_act && sum[PHASE_W];
  assign lut_addr = phase_acc[PHASE_W-1 -: ADDR_W];

  // Gain is unsigned, so extend it with a zero sign bit before the signed multiply.
  assign prod    = $signed(lut_data) * $signed({1'b0, gain});
  assign shifted = prod >>> 7;
  assign sat_val = (shifted > SAT_MAX) ? {1'b0, {(DATA_W-1){1'b1}}} :
                   (shifted < SAT_MIN) ? {1'b1, {(DATA_W-1){1'b0}}} :
                   shifted[DATA_W-1:0];

  // Next-state logic. Start takes priority over stop in IDLE and in DRAIN.
  // Stop takes priority over start in RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (stop) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (start)     state_nxt = S_RUN;
        else if (wrap) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register. busy is registered alongside it so busy always tracks the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // Phase accumulator, beat-rate register and beat counter.
  // A new rate is loaded only at a beat boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc  <= '0;
      inc_reg    <= '0;
      beat_count <= '0;
      beat_pulse <= 1'b0;
    end else begin
      beat_pulse <= wrap;
      if (state == S_IDLE) begin
        phase_acc <= '0;
        if (start) begin
          inc_reg    <= phase_inc;
          beat_count <= '0;
        end
      end else if (sample_tick) begin
        phase_acc <= (state_nxt == S_IDLE) ? '0 : sum[PHASE_W-1:0];
        if (wrap) begin
          beat_count <= beat_count + 16'd1;
          inc_reg    <= phase_inc;
        end
      end
    end
  end

  // Output stage. When the held sample is stalled, a new tick's sample is
  // dropped and overrun is latched. The time base still advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) overrun <= 1'b0;
      if (tick_act) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_data  <= sat_val;
          out_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecg_play_ctrl.sv
// Bench for ecg_play_ctrl: a combinational LUT model, a scoreboard queue of
// expected samples, a table of gain/saturation vectors, and directed
// sequences for stop, backpressure, rate change, start/stop races and
// asynchronous reset.
module tb_ecg_play_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic        start;
  logic        stop;
  logic [31:0] phase_inc;
  logic [7:0]  gain;
  logic [9:0]  lut_addr;
  logic [15:0] lut_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        beat_pulse;
  logic [15:0] beat_count;
  logic        overrun;

  logic [15:0] lut_mem [1024];
  logic [15:0] exp_q [$];
  int          total;
  int          bad;

  typedef struct {
    logic [15:0] lut;
    logic [7:0]  gain;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [12];

  ecg_play_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .start       (start),
    .stop        (stop),
    .phase_inc   (phase_inc),
    .gain        (gain),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .beat_pulse  (beat_pulse),
    .beat_count  (beat_count),
    .overrun     (overrun)
  );

  assign lut_data = lut_mem[lut_addr];

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference for the gain stage, used by the directed sequences.
  function automatic logic [15:0] scale(logic [15:0] v, logic [7:0] g);
    int p;
    p = int'($signed(v)) * int'({24'd0, g});
    p = p >>> 7;
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  // Scoreboard: every accepted output transfer pops one expected sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {16'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        chk("sample", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks. Inputs change 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic tick(bit push, logic [15:0] e);
    sample_tick = 1'b1;
    if (push) exp_q.push_back(e);
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    phase_inc   = '0;
    gain        = '0;
    out_ready   = 1'b1;
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic start_run(logic [31:0] inc, logic [7:0] g);
    phase_inc = inc;
    gain      = g;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic pulse(bit s_start, bit s_stop);
    start = s_start;
    stop  = s_stop;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_addr"},  {22'd0, lut_addr}, 32'd0);
    chk({tag, "_data"},  {16'd0, out_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, beat_pulse}, 32'd0);
    chk({tag, "_count"}, {16'd0, beat_count}, 32'd0);
    chk({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
  endtask

  logic [15:0] held;

  initial begin
    total = 0;
    bad   = 0;
    for (int a = 0; a < 1024; a++) lut_mem[a] = 16'((a * 2749 + 1234) ^ (a << 7));

    vecs[0]  = '{16'h7000, 8'hFF, 16'h7FFF};
    vecs[1]  = '{16'h8000, 8'hFF, 16'h8000};
    vecs[2]  = '{16'h4000, 8'h40, 16'h2000};
    vecs[3]  = '{16'h1234, 8'h80, 16'h1234};
    vecs[4]  = '{16'hFFFF, 8'h80, 16'hFFFF};
    vecs[5]  = '{16'hFFFF, 8'h01, 16'hFFFF};
    vecs[6]  = '{16'h0100, 8'h01, 16'h0002};
    vecs[7]  = '{16'h7FFF, 8'h80, 16'h7FFF};
    vecs[8]  = '{16'h8000, 8'h80, 16'h8000};
    vecs[9]  = '{16'hC000, 8'hFF, 16'h8080};
    vecs[10] = '{16'h4000, 8'h00, 16'h0000};
    vecs[11] = '{16'h0081, 8'h81, 16'h0082};

    // Reset state.
    do_reset();
    rst_n = 1'b0;
    cyc();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    cyc();

    // Full beat at unity gain: one address per tick, wrap after tick 1024.
    start_run(32'h0040_0000, 8'h80);
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 1024; i++) begin
      chk("t1_addr", {22'd0, lut_addr}, i);
      tick(1'b1, lut_mem[i]);
      chk("t1_valid_lat", {31'd0, out_valid}, 32'd1);
      chk("t1_pulse", {31'd0, beat_pulse}, (i == 1023) ? 32'd1 : 32'd0);
      idle(3);
      chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    end
    chk("t1_count", {16'd0, beat_count}, 32'd1);
    chk("t1_wrap_addr", {22'd0, lut_addr}, 32'd0);

    // Gain and saturation vectors, one per LUT entry.
    do_reset();
    start_run(32'h0040_0000, 8'h80);
    for (int i = 0; i < 12; i++) begin
      lut_mem[i] = vecs[i].lut;
      gain       = vecs[i].gain;
      tick(1'b1, vecs[i].exp);
      idle(1);
    end

    // Stop at address 500: keep playing to the end of the beat, then idle.
    do_reset();
    start_run(32'h0040_0000, 8'h80);
    for (int i = 0; i < 500; i++) begin
      tick(1'b1, lut_mem[i]);
      idle(1);
    end
    chk("stop_addr", {22'd0, lut_addr}, 32'd500);
    pulse(1'b0, 1'b1);
    chk("stop_busy", {31'd0, busy}, 32'd1);
    for (int i = 500; i < 1024; i++) begin
      tick(1'b1, lut_mem[i]);
      chk("drain_busy", {31'd0, busy}, (i == 1023) ? 32'd0 : 32'd1);
      idle(1);
    end
    chk("drain_addr", {22'd0, lut_addr}, 32'd0);
    chk("drain_count", {16'd0, beat_count}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'd0);
      chk("idle_tick_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_tick_addr", {22'd0, lut_addr}, 32'd0);
    end

    // Backpressure across two ticks.
    do_reset();
    start_run(32'h0040_0000, 8'hC0);
    out_ready = 1'b0;
    held = scale(lut_mem[0], 8'hC0);
    tick(1'b1, held);
    idle(1);
    tick(1'b0, 16'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_held", {16'd0, out_data}, {16'd0, held});
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    chk("bp_addr", {22'd0, lut_addr}, 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_queue", exp_q.size(), 32'd0);
    tick(1'b1, scale(lut_mem[2], 8'hC0));
    chk("bp_sticky", {31'd0, overrun}, 32'd1);
    idle(1);

    // Rate change mid-beat takes effect only after the wrap.
    do_reset();
    start_run(32'h0040_0000, 8'h80);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, lut_mem[i]);
      idle(1);
    end
    phase_inc = 32'h0080_0000;
    for (int i = 10; i < 1024; i++) begin
      chk("rate_old_addr", {22'd0, lut_addr}, i);
      tick(1'b1, lut_mem[i]);
      idle(1);
    end
    chk("rate_wrap_addr", {22'd0, lut_addr}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b1, lut_mem[2 * (k - 1)]);
      chk("rate_new_addr", {22'd0, lut_addr}, 2 * k);
      idle(1);
    end

    // Zero phase step: address holds and the same sample repeats.
    do_reset();
    start_run(32'h0, 8'h80);
    tick(1'b1, lut_mem[0]);
    idle(1);
    tick(1'b1, lut_mem[0]);
    idle(1);
    chk("zero_inc_addr", {22'd0, lut_addr}, 32'd0);

    // Simultaneous start and stop, using a two-tick beat.
    do_reset();
    phase_inc = 32'h8000_0000;
    gain      = 8'h40;
    pulse(1'b1, 1'b1);
    chk("ss_idle_busy", {31'd0, busy}, 32'd1);
    tick(1'b1, scale(lut_mem[0], 8'h40));   idle(1);
    tick(1'b1, scale(lut_mem[512], 8'h40)); idle(1);
    chk("ss_run_kept", {31'd0, busy}, 32'd1);
    chk("ss_run_count", {16'd0, beat_count}, 32'd1);
    pulse(1'b1, 1'b0);
    chk("ss_start_ignored", {16'd0, beat_count}, 32'd1);
    pulse(1'b1, 1'b1);
    chk("ss_drain_busy", {31'd0, busy}, 32'd1);
    tick(1'b1, scale(lut_mem[0], 8'h40));
    chk("ss_drain_mid", {31'd0, busy}, 32'd1);
    idle(1);
    tick(1'b1, scale(lut_mem[512], 8'h40));
    chk("ss_drain_idle", {31'd0, busy}, 32'd0);
    chk("ss_drain_count", {16'd0, beat_count}, 32'd2);
    idle(1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    tick(1'b1, scale(lut_mem[0], 8'h40));   idle(1);
    tick(1'b1, scale(lut_mem[512], 8'h40)); idle(1);
    chk("resume_busy", {31'd0, busy}, 32'd1);
    chk("resume_count", {16'd0, beat_count}, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset while a stalled sample is held.
    do_reset();
    start_run(32'h8000_0000, 8'h80);
    out_ready = 1'b0;
    tick(1'b1, lut_mem[0]);
    idle(1);
    tick(1'b0, 16'd0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_pulse", {31'd0, beat_pulse}, 32'd1);
    chk("pre_rst_ovr", {31'd0, overrun}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
